// File: rtl/io_bridge_pkg.sv
// io_port_bridge shared definitions.
// Port map defaults and status bit positions.
package io_bridge_pkg;

  localparam logic [7:0] LED_ID_DEF   = 8'h40;
  localparam logic [7:0] TX_ID_DEF    = 8'h41;
  localparam logic [7:0] STAT_ID_DEF  = 8'h42;
  localparam logic [7:0] IRQEN_ID_DEF = 8'h43;
  localparam logic [7:0] SW_ID_DEF    = 8'h44;
  localparam logic [7:0] CNT_ID_DEF   = 8'h45;

  localparam int ST_TXE_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_PTXE      = 3;
  localparam int ST_PSW       = 4;

endpackage

// File: rtl/io_tx_fifo.sv
// io_port_bridge TX byte FIFO.
// Head is registered storage; full push with pop is accepted.
module io_tx_fifo
  import io_bridge_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     ready_i,
  output logic [7:0]               data_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ovf_o,
  output logic                     drain_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    mem_q [DEPTH];
  logic          pop;
  logic          acc;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign valid_o = ~empty_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign pop     = valid_o & ready_i;
  assign acc     = push_i & (~full_o | pop);
  assign ovf_o   = push_i & full_o & ~pop;
  assign drain_o = pop & (cnt_q == CW'(1)) & ~push_i;

  // Pointer and occupancy next-state
  always_comb begin
    wr_d  = wr_q + AW'(acc);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + CW'(acc) - CW'(pop);
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Byte storage, cleared so the idle head reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (acc) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/io_port_bridge.sv
// io_port_bridge: CPU port decode, LEDs, TX FIFO, IRQ.
// Optional switch-change IRQ under IO_BRIDGE_SW_IRQ_EN.
module io_port_bridge
  import io_bridge_pkg::*;
#(
  parameter int         TX_DEPTH = 8,
  parameter logic [7:0] LED_ID   = LED_ID_DEF,
  parameter logic [7:0] TX_ID    = TX_ID_DEF,
  parameter logic [7:0] STAT_ID  = STAT_ID_DEF,
  parameter logic [7:0] IRQEN_ID = IRQEN_ID_DEF,
  parameter logic [7:0] SW_ID    = SW_ID_DEF,
  parameter logic [7:0] CNT_ID   = CNT_ID_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       io_strb,
  output logic [7:0] in_port,
  output logic       interrupt,
  output logic [7:0] leds,
  input  logic [7:0] switches,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [7:0]    leds_q, leds_d;
  logic [1:0]    en_q, en_d;
  logic          ovf_q, ovf_d;
  logic          ptxe_q, ptxe_d;
  logic          psw_q, psw_d;
  logic          irq_q, irq_d;
  logic [7:0]    sw_meta_q, sw_sync_q;
  logic          wr_led, wr_tx, wr_stat, wr_en;
  logic          full, empty, ovf_set, drain;
  logic [CW-1:0] count;
  logic [7:0]    status;

  assign wr_led  = io_strb & (port_id == LED_ID);
  assign wr_tx   = io_strb & (port_id == TX_ID);
  assign wr_stat = io_strb & (port_id == STAT_ID);
  assign wr_en   = io_strb & (port_id == IRQEN_ID);

  io_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_tx),
    .data_i  (out_port),
    .ready_i (tx_ready),
    .data_o  (tx_data),
    .valid_o (tx_valid),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .ovf_o   (ovf_set),
    .drain_o (drain)
  );

  // Two-flop switch synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
    end
  end

`ifdef IO_BRIDGE_SW_IRQ_EN
  logic [7:0] sw_prev_q;

  // Previous synchronized switch value for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sw_prev_q <= '0;
    else        sw_prev_q <= sw_sync_q;
  end

  // Switch-change flag: set beats ack
  always_comb begin
    psw_d = (sw_sync_q != sw_prev_q) |
            (psw_q & ~(wr_stat & out_port[ST_PSW]));
  end
`else
  // Switch IRQ not built
  always_comb begin
    psw_d = 1'b0;
  end
`endif

  // Register and flag next-state
  always_comb begin
    leds_d = leds_q;
    en_d   = en_q;
    if (wr_led) leds_d = out_port;
    if (wr_en)  en_d   = out_port[4:3];
    ovf_d  = ovf_set |
             (ovf_q & ~(wr_stat & out_port[ST_OVF]));
    ptxe_d = drain |
             (ptxe_q & ~(wr_stat & out_port[ST_PTXE]));
    irq_d  = |({psw_q, ptxe_q} & en_q);
  end

  // Bridge state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds_q <= '0;
      en_q   <= '0;
      ovf_q  <= 1'b0;
      ptxe_q <= 1'b0;
      psw_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      leds_q <= leds_d;
      en_q   <= en_d;
      ovf_q  <= ovf_d;
      ptxe_q <= ptxe_d;
      psw_q  <= psw_d;
      irq_q  <= irq_d;
    end
  end

  assign status = {3'b000, psw_q, ptxe_q,
                   ovf_q, full, empty};

  // Side-effect-free read mux
  always_comb begin
    in_port = 8'h00;
    if (port_id == LED_ID)
      in_port = leds_q;
    else if (port_id == STAT_ID)
      in_port = status;
    else if (port_id == IRQEN_ID)
      in_port = {3'b000, en_q, 3'b000};
    else if (port_id == SW_ID)
      in_port = sw_sync_q;
    else if (port_id == CNT_ID)
      in_port = 8'(count);
  end

  assign leds      = leds_q;
  assign interrupt = irq_q;

endmodule

// File: tb/tb_io_port_bridge.sv
// io_port_bridge bench: queue-based model plus directed checks.
// Build with IO_BRIDGE_SW_IRQ_EN to cover the switch IRQ.
module tb_io_port_bridge;

  localparam int DEPTH = 8;

  logic       clk = 0;
  logic       rst_n = 0;
  logic [7:0] port_id = 0;
  logic [7:0] out_port = 0;
  logic       io_strb = 0;
  logic [7:0] in_port;
  logic       interrupt;
  logic [7:0] leds;
  logic [7:0] switches = 0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 0;

  int n_chk = 0;
  int n_fail = 0;

  io_port_bridge dut (
    .clk(clk), .rst_n(rst_n), .port_id(port_id),
    .out_port(out_port), .io_strb(io_strb),
    .in_port(in_port), .interrupt(interrupt),
    .leds(leds), .switches(switches),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // Behavioural model
  logic [7:0] m_leds, m_en, m_s1, m_s2, m_prev;
  bit         m_ovf, m_ptxe, m_psw, m_irq;
  logic [7:0] m_q [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_leds = 0; m_en = 0; m_s1 = 0; m_s2 = 0;
      m_prev = 0; m_ovf = 0; m_ptxe = 0;
      m_psw = 0; m_irq = 0;
      m_q.delete();
    end else begin
      bit pop, push, wst, was_full, sw_chg;
      int sz;
      sz = m_q.size();
      pop  = (sz > 0) && tx_ready;
      push = io_strb && port_id == 8'h41;
      wst  = io_strb && port_id == 8'h42;
      was_full = (sz == DEPTH);
      m_irq = (m_ptxe && m_en[3]) || (m_psw && m_en[4]);
`ifdef IO_BRIDGE_SW_IRQ_EN
      sw_chg = (m_s2 != m_prev);
`else
      sw_chg = 0;
`endif
      if (pop) void'(m_q.pop_front());
      if (push && (!was_full || pop))
        m_q.push_back(out_port);
      m_ovf  = (push && was_full && !pop) ||
               (m_ovf && !(wst && out_port[2]));
      m_ptxe = (pop && sz == 1 && !push) ||
               (m_ptxe && !(wst && out_port[3]));
      m_psw  = sw_chg ||
               (m_psw && !(wst && out_port[4]));
      if (io_strb && port_id == 8'h40) m_leds = out_port;
      if (io_strb && port_id == 8'h43)
        m_en = out_port & 8'h18;
      m_prev = m_s2; m_s2 = m_s1; m_s1 = switches;
    end
  end

  function automatic logic [7:0] m_read(logic [7:0] id);
    int sz;
    sz = m_q.size();
    case (id)
      8'h40: return m_leds;
      8'h42: return {3'b0, m_psw, m_ptxe, m_ovf,
                     sz == DEPTH, sz == 0};
      8'h43: return m_en;
      8'h44: return m_s2;
      8'h45: return 8'(sz);
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(string nm, logic [7:0] act,
                       logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h",
               nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("m_leds", leds, m_leds);
    check("m_txv", {7'b0, tx_valid},
          {7'b0, m_q.size() > 0});
    if (m_q.size() > 0)
      check("m_txd", tx_data, m_q[0]);
    check("m_irq", {7'b0, interrupt}, {7'b0, m_irq});
    check("m_in", in_port, m_read(port_id));
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(logic [7:0] id, logic [7:0] d);
    port_id = id; out_port = d; io_strb = 1;
    cyc();
    io_strb = 0;
  endtask

  task automatic rd(string nm, logic [7:0] id,
                    logic [7:0] exp);
    port_id = id; #1;
    check(nm, in_port, exp);
  endtask

  logic [7:0] got [$];
  logic [7:0] want [$];

  initial begin
    #12;
    check("rst_txd", tx_data, 8'h00);
    check("rst_txv", {7'b0, tx_valid}, 8'h00);
    rst_n = 1;
    cyc();

    wr(8'h40, 8'hA5);
    check("leds", leds, 8'hA5);
    rd("rd_led", 8'h40, 8'hA5);
    rd("rd_unm", 8'h7F, 8'h00);

    tx_ready = 0;
    for (int i = 0; i < 8; i++)
      wr(8'h41, 8'(8'h11 + i));
    rd("st_full", 8'h42, 8'h02);
    rd("cnt8", 8'h45, 8'h08);
    wr(8'h41, 8'h99);
    rd("st_ovf", 8'h42, 8'h06);

    tx_ready = 1;
    wr(8'h41, 8'h55);
    rd("cnt_pp", 8'h45, 8'h08);
    for (int i = 0; i < 12; i++) begin
      if (tx_valid) got.push_back(tx_data);
      cyc();
    end
    want = '{8'h12, 8'h13, 8'h14, 8'h15,
             8'h16, 8'h17, 8'h18, 8'h55};
    check("drain_n", 8'(got.size()), 8'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      check("drain_d", got[i], want[i]);
    rd("st_drn", 8'h42, 8'h0D);
    wr(8'h42, 8'h1C);
    rd("st_clr", 8'h42, 8'h01);

    wr(8'h43, 8'h08);
    rd("rd_en", 8'h43, 8'h08);
    tx_ready = 0;
    wr(8'h41, 8'h3C);
    tx_ready = 1;
    cyc();
    rd("ptxe", 8'h42, 8'h09);
    check("irq0", {7'b0, interrupt}, 8'h00);
    cyc();
    check("irq1", {7'b0, interrupt}, 8'h01);
    wr(8'h42, 8'h08);
    cyc();
    check("irq_clr", {7'b0, interrupt}, 8'h00);

    tx_ready = 0;
    wr(8'h41, 8'h77);
    tx_ready = 1;
    wr(8'h42, 8'h08);
    rd("set_win", 8'h42, 8'h09);
    wr(8'h42, 8'h08);
    wr(8'h43, 8'h10);
    cyc();

    switches = 8'h81;
    cyc(); cyc();
    rd("sw_sync", 8'h44, 8'h81);
`ifdef IO_BRIDGE_SW_IRQ_EN
    cyc();
    rd("psw", 8'h42, 8'h11);
    cyc();
    check("sw_irq", {7'b0, interrupt}, 8'h01);
`else
    cyc(); cyc();
    rd("psw0", 8'h42, 8'h01);
    check("sw_noirq", {7'b0, interrupt}, 8'h00);
`endif
    wr(8'h42, 8'h1C);
    wr(8'h43, 8'h00);

    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 7);
      port_id = (r < 6) ? 8'(8'h40 + r) : 8'($urandom);
      io_strb = ($urandom_range(0, 2) != 0);
      out_port = 8'($urandom);
      tx_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0)
        switches = 8'($urandom);
      cyc();
    end
    io_strb = 0;

    tx_ready = 0;
    wr(8'h42, 8'h1C);
    wr(8'h43, 8'h08);
    wr(8'h41, 8'h01);
    tx_ready = 1;
    cyc();
    tx_ready = 0;
    wr(8'h41, 8'h02);
    wr(8'h41, 8'h03);
    wr(8'h40, 8'h5A);
    check("pre_txv", {7'b0, tx_valid}, 8'h01);
    check("pre_irq", {7'b0, interrupt}, 8'h01);
    tx_ready = 1;
    #3 rst_n = 0;
    #1;
    check("ar_txv", {7'b0, tx_valid}, 8'h00);
    check("ar_irq", {7'b0, interrupt}, 8'h00);
    check("ar_led", leds, 8'h00);
    rd("ar_cnt", 8'h45, 8'h00);
    #20;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
